branch_predictor: RTL and testbench

- Branch target buffer (BTB) plus optional branch history table (BHT) of 2-bit counters. It is the receiving end of the pipeline controller's btb_pc_we / btb_pc_clear / bht_we update strobes.
- Looks up the IF-stage PC combinationally and gives the fetch unit a predicted-taken flag and target.
- Carries the prediction through ID and EX stage registers under the controller's stall/clear signals, and returns it to the controller in EX as the branch prediction.

---
 rtl/branch_predictor_pkg.sv | 39 +++
 rtl/branch_predictor_bht.sv | 45 ++++
 rtl/branch_predictor.sv | 165 ++++++++++++++++
 tb/tb_branch_predictor.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_pkg
// Purpose  : Shared types and constants for the branch predictor slice:
//            default table sizes, the 2-bit BHT counter type with its named
//            states, the BTB entry record and the saturating counter update.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package branch_predictor_pkg;

  localparam int BTB_ENTRIES_DEFAULT = 64;
  localparam int BHT_ENTRIES_DEFAULT = 256;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t STRONG_NT = 2'b00;
  localparam bht_ctr_t WEAK_NT   = 2'b01;
  localparam bht_ctr_t WEAK_T    = 2'b10;
  localparam bht_ctr_t STRONG_T  = 2'b11;

  // Tag is kept at full 32-bit width (zero-extended PC upper bits) so the
  // record layout does not depend on the BTB size.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
  } btb_entry_t;

  // 2-bit saturating counter step towards the resolved outcome.
  function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
    bht_ctr_t r;
    if (taken) r = (c == STRONG_T)  ? STRONG_T  : bht_ctr_t'(c + 2'd1);
    else       r = (c == STRONG_NT) ? STRONG_NT : bht_ctr_t'(c - 2'd1);
    return r;
  endfunction

endpackage : branch_predictor_pkg
`default_nettype wire

// File: rtl/branch_predictor_bht.sv
`default_nettype none
// ============================================================================
// Module   : bht_counter_array
// Purpose  : Array of 2-bit saturating branch-history counters with one
//            combinational read port and one synchronous update port.
//            Reset returns every counter to WEAK_NT.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_rd_idx        - read index (IF-stage lookup)
//            o_rd_ctr        - counter value at i_rd_idx (pre-update value)
//            i_we            - update strobe
//            i_wr_idx        - counter to update
//            i_taken         - resolved outcome driving the update direction
// Revision : 1.0 - initial release
// ============================================================================
module bht_counter_array
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = BHT_ENTRIES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(ENTRIES)-1:0] i_rd_idx,
  output bht_ctr_t                   o_rd_ctr,
  input  logic                       i_we,
  input  logic [$clog2(ENTRIES)-1:0] i_wr_idx,
  input  logic                       i_taken
);

  bht_ctr_t r_ctr [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= WEAK_NT;
      end
    end else if (i_we) begin
      r_ctr[i_wr_idx] <= ctr_next(r_ctr[i_wr_idx], i_taken);
    end
  end

  // Read straight from the flops: a same-cycle update is not bypassed.
  assign o_rd_ctr = r_ctr[i_rd_idx];

endmodule : bht_counter_array
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Branch target buffer with optional 2-bit BHT. Looks up the
//            IF-stage PC combinationally, carries the prediction through ID
//            and EX stage flops and applies BTB/BHT updates from EX.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            pc_if_i                   - IF fetch PC
//            pred_taken_if_o           - predicted taken for pc_if_i
//            pred_target_if_o          - predicted target (0 if not taken)
//            stall_id_i / clear_id_i   - ID stage-register control
//            stall_ex_i / clear_ex_i   - EX stage-register control
//            branch_prediction_ex_o    - prediction of the EX instruction
//            pc_ex_i                   - EX branch PC (update index)
//            branch_target_ex_i        - resolved target
//            branch_taken_ex_i         - resolved outcome
//            btb_we_i / btb_clear_i    - BTB write / invalidate (clear wins)
//            bht_we_i                  - BHT counter update
//            stat_lookups_o            - lookups captured into ID
//            stat_mispredicts_o        - cycles with any update strobe
// Config   : BRANCH_PRED_STATS_EN - builds the saturating statistics
//            counters; otherwise both stat ports are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BTB_ENTRIES = BTB_ENTRIES_DEFAULT,
  parameter int BHT_ENTRIES = BHT_ENTRIES_DEFAULT,
  parameter bit USE_BHT     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_if_i,
  output logic        pred_taken_if_o,
  output logic [31:0] pred_target_if_o,
  input  logic        stall_id_i,
  input  logic        clear_id_i,
  input  logic        stall_ex_i,
  input  logic        clear_ex_i,
  output logic        branch_prediction_ex_o,
  input  logic [31:0] pc_ex_i,
  input  logic [31:0] branch_target_ex_i,
  input  logic        branch_taken_ex_i,
  input  logic        btb_we_i,
  input  logic        btb_clear_i,
  input  logic        bht_we_i,
  output logic [31:0] stat_lookups_o,
  output logic [31:0] stat_mispredicts_o
);

  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int BW = $clog2(BHT_ENTRIES);

  // --------------------------------------------------------------------------
  // BTB storage and indexing
  // --------------------------------------------------------------------------
  btb_entry_t r_btb [BTB_ENTRIES];

  logic [IW-1:0] w_if_idx;
  logic [IW-1:0] w_ex_idx;
  logic [31:0]   w_if_tag;
  logic [31:0]   w_ex_tag;
  btb_entry_t    w_if_entry;
  logic          w_hit;

  assign w_if_idx = pc_if_i[IW+1:2];
  assign w_ex_idx = pc_ex_i[IW+1:2];
  assign w_if_tag = pc_if_i >> (IW + 2);
  assign w_ex_tag = pc_ex_i >> (IW + 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      // Tags and targets are left as they are; only valid matters.
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb[i].valid <= 1'b0;
      end
    end else if (btb_clear_i) begin
      r_btb[w_ex_idx].valid <= 1'b0;
    end else if (btb_we_i) begin
      r_btb[w_ex_idx] <= '{valid: 1'b1, tag: w_ex_tag, target: branch_target_ex_i};
    end
  end

  assign w_if_entry = r_btb[w_if_idx];
  assign w_hit      = w_if_entry.valid && (w_if_entry.tag == w_if_tag);

  // --------------------------------------------------------------------------
  // Direction predictor: BHT counter, or "always taken on hit" without it
  // --------------------------------------------------------------------------
  bht_ctr_t w_bht_ctr;

  generate
    if (USE_BHT) begin : g_bht
      bht_counter_array #(
        .ENTRIES (BHT_ENTRIES)
      ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .i_rd_idx (pc_if_i[BW+1:2]),
        .o_rd_ctr (w_bht_ctr),
        .i_we     (bht_we_i),
        .i_wr_idx (pc_ex_i[BW+1:2]),
        .i_taken  (branch_taken_ex_i)
      );
    end else begin : g_no_bht
      assign w_bht_ctr = STRONG_T;
    end
  endgenerate

  assign pred_taken_if_o  = w_hit && w_bht_ctr[1];
  assign pred_target_if_o = pred_taken_if_o ? w_if_entry.target : 32'd0;

  // --------------------------------------------------------------------------
  // ID / EX prediction stage flops (stall beats clear)
  // --------------------------------------------------------------------------
  logic r_pred_id;
  logic r_pred_ex;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pred_id <= 1'b0;
      r_pred_ex <= 1'b0;
    end else begin
      if (!stall_id_i) r_pred_id <= clear_id_i ? 1'b0 : pred_taken_if_o;
      if (!stall_ex_i) r_pred_ex <= clear_ex_i ? 1'b0 : r_pred_id;
    end
  end

  assign branch_prediction_ex_o = r_pred_ex;

  // --------------------------------------------------------------------------
  // Optional statistics
  // --------------------------------------------------------------------------
`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] r_stat_lookups;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_lookups     <= 32'd0;
      r_stat_mispredicts <= 32'd0;
    end else begin
      if (!stall_id_i && !clear_id_i && (r_stat_lookups != 32'hFFFF_FFFF))
        r_stat_lookups <= r_stat_lookups + 32'd1;
      if ((btb_we_i || btb_clear_i || bht_we_i) && (r_stat_mispredicts != 32'hFFFF_FFFF))
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_lookups_o     = r_stat_lookups;
  assign stat_mispredicts_o = r_stat_mispredicts;
`else
  assign stat_lookups_o     = 32'd0;
  assign stat_mispredicts_o = 32'd0;
`endif

  // Byte-offset bits and, in some configurations, BHT inputs and the
  // counter's hysteresis bit have no consumer.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, pc_if_i[1:0], pc_ex_i[1:0], w_bht_ctr[0],
                         bht_we_i, branch_taken_ex_i};

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Directed self-checking bench. Two instances share every input:
//            dut_a without the BHT (USE_BHT = 0) and dut_b with it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        stall_id, clear_id, stall_ex, clear_ex;
  logic [31:0] pc_ex, tgt_ex;
  logic        taken_ex, btb_we, btb_clear, bht_we;

  logic        a_taken, a_pred_ex, b_taken, b_pred_ex;
  logic [31:0] a_target, b_target, a_sl, a_sm, b_sl, b_sm;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor #(.USE_BHT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .pc_if_i(pc_if),
    .pred_taken_if_o(a_taken), .pred_target_if_o(a_target),
    .stall_id_i(stall_id), .clear_id_i(clear_id),
    .stall_ex_i(stall_ex), .clear_ex_i(clear_ex),
    .branch_prediction_ex_o(a_pred_ex),
    .pc_ex_i(pc_ex), .branch_target_ex_i(tgt_ex), .branch_taken_ex_i(taken_ex),
    .btb_we_i(btb_we), .btb_clear_i(btb_clear), .bht_we_i(bht_we),
    .stat_lookups_o(a_sl), .stat_mispredicts_o(a_sm)
  );

  branch_predictor #(.USE_BHT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .pc_if_i(pc_if),
    .pred_taken_if_o(b_taken), .pred_target_if_o(b_target),
    .stall_id_i(stall_id), .clear_id_i(clear_id),
    .stall_ex_i(stall_ex), .clear_ex_i(clear_ex),
    .branch_prediction_ex_o(b_pred_ex),
    .pc_ex_i(pc_ex), .branch_target_ex_i(tgt_ex), .branch_taken_ex_i(taken_ex),
    .btb_we_i(btb_we), .btb_clear_i(btb_clear), .bht_we_i(bht_we),
    .stat_lookups_o(b_sl), .stat_mispredicts_o(b_sm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are changed 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_sl;
    logic [31:0] exp_sm;
`ifdef BRANCH_PRED_STATS_EN
    exp_sl = 32'd10;
    exp_sm = 32'd2;
`else
    exp_sl = 32'd0;
    exp_sm = 32'd0;
`endif

    rst = 1'b1; pc_if = 32'h0; stall_id = 1'b0; clear_id = 1'b0;
    stall_ex = 1'b0; clear_ex = 1'b0; pc_ex = 32'h0; tgt_ex = 32'h0;
    taken_ex = 1'b0; btb_we = 1'b0; btb_clear = 1'b0; bht_we = 1'b0;
    step(); step();

    // Reset state
    rst = 1'b0; pc_if = 32'h100; #1;
    chk("rst_a_taken",  {31'd0, a_taken},   32'd0);
    chk("rst_a_target", a_target,           32'd0);
    chk("rst_b_taken",  {31'd0, b_taken},   32'd0);
    chk("rst_a_pred_ex",{31'd0, a_pred_ex}, 32'd0);
    chk("rst_b_pred_ex",{31'd0, b_pred_ex}, 32'd0);
    chk("rst_a_sl",     a_sl,               32'd0);
    chk("rst_b_sm",     b_sm,               32'd0);

    // BTB learn: same-cycle lookup sees the old (invalid) entry
    btb_we = 1'b1; pc_ex = 32'h100; tgt_ex = 32'h200; #1;
    chk("nobypass_a_taken", {31'd0, a_taken}, 32'd0);
    step();
    btb_we = 1'b0; #1;
    chk("learn_a_taken",  {31'd0, a_taken}, 32'd1);
    chk("learn_a_target", a_target,         32'h200);
    chk("learn_b_taken",  {31'd0, b_taken}, 32'd0);
    chk("learn_b_target", b_target,         32'd0);
    step();
    chk("learn_a_ex_c1", {31'd0, a_pred_ex}, 32'd0);
    step();
    chk("learn_a_ex_c2", {31'd0, a_pred_ex}, 32'd1);

    // Alias: same index, different tag
    pc_if = 32'h200; #1;
    chk("alias_a_taken",  {31'd0, a_taken}, 32'd0);
    chk("alias_a_target", a_target,         32'd0);

    // BHT saturation on dut_b: counter 01 -> 10 -> 11 -> 11
    pc_if = 32'h100; pc_ex = 32'h100; taken_ex = 1'b1; bht_we = 1'b1; #1;
    chk("bht_ctr01", {31'd0, b_taken}, 32'd0);
    step();
    chk("bht_ctr10", {31'd0, b_taken}, 32'd1);
    chk("bht_ctr10_tgt", b_target, 32'h200);
    step();
    chk("bht_ctr11", {31'd0, b_taken}, 32'd1);
    step();
    chk("bht_ctr11_sat", {31'd0, b_taken}, 32'd1);
    taken_ex = 1'b0;
    step();
    bht_we = 1'b0; #1;
    chk("bht_nt_ctr10", {31'd0, b_taken}, 32'd1);
    chk("bht_a_ignored", {31'd0, a_taken}, 32'd1);
    bht_we = 1'b1;
    step();
    bht_we = 1'b0; #1;
    chk("bht_nt_ctr01", {31'd0, b_taken}, 32'd0);

    // Stall/clear on ID with dut_a (pred_id = 1, pred_ex = 1 here)
    chk("pre_stall_ex", {31'd0, a_pred_ex}, 32'd1);
    stall_id = 1'b1; clear_id = 1'b1; pc_if = 32'h300;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_id_hold", {31'd0, a_pred_ex}, 32'd1);
    end
    stall_id = 1'b0;
    step();
    chk("release_ex_c1", {31'd0, a_pred_ex}, 32'd1);
    step();
    chk("release_ex_c2", {31'd0, a_pred_ex}, 32'd0);
    clear_id = 1'b0;

    // EX stage: stall holds even with clear, clear alone zeroes
    pc_if = 32'h100;
    step(); step();
    chk("ex_refill", {31'd0, a_pred_ex}, 32'd1);
    stall_ex = 1'b1; clear_ex = 1'b1;
    step();
    chk("ex_stall_hold", {31'd0, a_pred_ex}, 32'd1);
    stall_ex = 1'b0;
    step();
    chk("ex_clear", {31'd0, a_pred_ex}, 32'd0);
    clear_ex = 1'b0;

    // Write and clear together: clear wins
    pc_ex = 32'h100; tgt_ex = 32'h200; btb_we = 1'b1; btb_clear = 1'b1;
    step();
    btb_we = 1'b0; btb_clear = 1'b0; #1;
    chk("we_clr_a_taken",  {31'd0, a_taken}, 32'd0);
    chk("we_clr_a_target", a_target,         32'd0);

    // Statistics: reset, then exactly 10 unstalled cycles with 2 strobes
    btb_we = 1'b1;
    step();
    btb_we = 1'b0;
    rst = 1'b1; stall_id = 1'b1; btb_clear = 1'b1;
    step();
    rst = 1'b0; btb_clear = 1'b0; #1;
    chk("rst2_b_taken", {31'd0, b_taken}, 32'd0);
    chk("rst2_a_taken", {31'd0, a_taken}, 32'd0);
    stall_id = 1'b0; pc_ex = 32'h400;
    for (int i = 0; i < 10; i++) begin
      btb_clear = (i == 2 || i == 6);
      step();
    end
    btb_clear = 1'b0; stall_id = 1'b1; #1;
    chk("stat_a_lookups",     a_sl, exp_sl);
    chk("stat_a_mispredicts", a_sm, exp_sm);
    chk("stat_b_lookups",     b_sl, exp_sl);
    chk("stat_b_mispredicts", b_sm, exp_sm);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_branch_predictor
`default_nettype wire
